// File: rtl/spike_window_monitor.sv
// Windowed spike counter and pre->post latency monitor for the STDP neuron pair.
// Publishes one snapshot record per window through a single-entry valid/ready buffer.
module spike_window_monitor #(
    parameter int unsigned WIN_BITS  = 8,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned LAT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 pre_spike_i,
    input  logic                 post_spike_i,
    input  logic [WIN_BITS-1:0]  window_len_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] pre_count_o,
    output logic [CNT_WIDTH-1:0] post_count_o,
    output logic [LAT_WIDTH-1:0] last_latency_o,
    output logic                 lat_valid_o,
    output logic                 cnt_sat_o,
    output logic                 overrun_o
);

    localparam int unsigned WinW = WIN_BITS + 1;
    localparam logic [WinW-1:0]      WinOne = WinW'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [LAT_WIDTH-1:0] LatOne = LAT_WIDTH'(1);
    localparam logic [LAT_WIDTH-1:0] LatMax = '1;

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    state_e               state_q, state_d;
    logic [WinW-1:0]      win_q, win_d;
    logic [WinW-1:0]      cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_WIDTH-1:0] post_cnt_q, post_cnt_d;
    logic                 sat_q, sat_d;
    logic [LAT_WIDTH-1:0] win_lat_q, win_lat_d;
    logic                 win_lv_q, win_lv_d;
    logic                 armed_q, armed_d;
    logic [LAT_WIDTH-1:0] lat_run_q, lat_run_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] rec_pre_q, rec_pre_d;
    logic [CNT_WIDTH-1:0] rec_post_q, rec_post_d;
    logic [LAT_WIDTH-1:0] rec_lat_q, rec_lat_d;
    logic                 rec_lv_q, rec_lv_d;
    logic                 rec_sat_q, rec_sat_d;
    logic                 overrun_q, overrun_d;

    logic [WinW-1:0]      win_sel;
    logic                 last_cycle;
    logic                 snap;
    logic [LAT_WIDTH-1:0] lat_now;
    logic                 pair;
    logic [LAT_WIDTH-1:0] pair_lat;
    logic [CNT_WIDTH-1:0] pre_nx, post_nx;
    logic                 sat_nx;
    logic [LAT_WIDTH-1:0] lat_nx;
    logic                 lv_nx;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cyc_d       = cyc_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        sat_d       = sat_q;
        win_lat_d   = win_lat_q;
        win_lv_d    = win_lv_q;
        armed_d     = armed_q;
        lat_run_d   = lat_run_q;
        out_valid_d = out_valid_q;
        rec_pre_d   = rec_pre_q;
        rec_post_d  = rec_post_q;
        rec_lat_d   = rec_lat_q;
        rec_lv_d    = rec_lv_q;
        rec_sat_d   = rec_sat_q;
        overrun_d   = overrun_q;
        snap        = 1'b0;

        // A programmed length of 0 selects the full 2^WIN_BITS window.
        win_sel    = {(window_len_i == '0), window_len_i};
        last_cycle = (state_q == StCount) && (cyc_q == win_q - WinOne);

        // Tracker runs in every state so pairings may straddle window edges.
        lat_now  = (lat_run_q == LatMax) ? LatMax : lat_run_q + LatOne;
        pair     = post_spike_i & (pre_spike_i | armed_q);
        pair_lat = pre_spike_i ? '0 : lat_now;
        if (armed_q) lat_run_d = lat_now;
        if (pre_spike_i && !post_spike_i) begin
            armed_d   = 1'b1;
            lat_run_d = '0;
        end else if (post_spike_i) begin
            armed_d = 1'b0;
        end

        pre_nx  = pre_cnt_q;
        post_nx = post_cnt_q;
        sat_nx  = sat_q;
        lat_nx  = win_lat_q;
        lv_nx   = win_lv_q;
        if (pre_spike_i) begin
            if (pre_cnt_q == CntMax) sat_nx = 1'b1;
            else                     pre_nx = pre_cnt_q + CntOne;
        end
        if (post_spike_i) begin
            if (post_cnt_q == CntMax) sat_nx  = 1'b1;
            else                      post_nx = post_cnt_q + CntOne;
        end
        if (pair) begin
            lat_nx = pair_lat;
            lv_nx  = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                pre_cnt_d  = '0;
                post_cnt_d = '0;
                sat_d      = 1'b0;
                win_lat_d  = '0;
                win_lv_d   = 1'b0;
                cyc_d      = '0;
                if (en_i) begin
                    win_d   = win_sel;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (last_cycle) begin
                    snap       = 1'b1;
                    cyc_d      = '0;
                    pre_cnt_d  = '0;
                    post_cnt_d = '0;
                    sat_d      = 1'b0;
                    win_lat_d  = '0;
                    win_lv_d   = 1'b0;
                    if (en_i) win_d   = win_sel;
                    else      state_d = StIdle;
                end else begin
                    cyc_d      = cyc_q + WinOne;
                    pre_cnt_d  = pre_nx;
                    post_cnt_d = post_nx;
                    sat_d      = sat_nx;
                    win_lat_d  = lat_nx;
                    win_lv_d   = lv_nx;
                end
            end
            default: state_d = StIdle;
        endcase

        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
        if (snap) begin
            if (!out_valid_q || out_ready_i) begin
                out_valid_d = 1'b1;
                rec_pre_d   = pre_nx;
                rec_post_d  = post_nx;
                rec_lat_d   = lat_nx;
                rec_lv_d    = lv_nx;
                rec_sat_d   = sat_nx;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            win_q       <= '0;
            cyc_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            sat_q       <= 1'b0;
            win_lat_q   <= '0;
            win_lv_q    <= 1'b0;
            armed_q     <= 1'b0;
            lat_run_q   <= '0;
            out_valid_q <= 1'b0;
            rec_pre_q   <= '0;
            rec_post_q  <= '0;
            rec_lat_q   <= '0;
            rec_lv_q    <= 1'b0;
            rec_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cyc_q       <= cyc_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            sat_q       <= sat_d;
            win_lat_q   <= win_lat_d;
            win_lv_q    <= win_lv_d;
            armed_q     <= armed_d;
            lat_run_q   <= lat_run_d;
            out_valid_q <= out_valid_d;
            rec_pre_q   <= rec_pre_d;
            rec_post_q  <= rec_post_d;
            rec_lat_q   <= rec_lat_d;
            rec_lv_q    <= rec_lv_d;
            rec_sat_q   <= rec_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign pre_count_o    = rec_pre_q;
    assign post_count_o   = rec_post_q;
    assign last_latency_o = rec_lat_q;
    assign lat_valid_o    = rec_lv_q;
    assign cnt_sat_o      = rec_sat_q;
    assign overrun_o      = overrun_q;

endmodule

// File: doc/spike_window_monitor.md
# spike_window_monitor

Windowed spike-train monitor sitting directly downstream of the two-neuron STDP pair. It consumes the presynaptic (neuron 1) and postsynaptic (neuron 2) spike pulses, counts each over a programmable window of clock cycles, and measures the pre-to-post spike latency. At each window end it publishes a snapshot record through a single-entry valid/ready output buffer for readout logic.

## Interface
- `WIN_BITS`, default 8: width of `window_len`; window length 0 means 2^WIN_BITS cycles.
- `CNT_WIDTH`, default 8: width of the spike counters.
- `LAT_WIDTH`, default 8: width of the latency measurement.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high; clears all state.
- `en` input 1: run request; sampled in IDLE and at each window end.
- `pre_spike` input 1: neuron 1 spike pulse, one cycle per spike.
- `post_spike` input 1: neuron 2 spike pulse.
- `window_len` input WIN_BITS: window length in cycles, latched at window start.
- `out_valid` output 1: snapshot record is present.
- `out_ready` input 1: consumer accepts the record.
- `pre_count` output CNT_WIDTH: pre spikes counted in the window.
- `post_count` output CNT_WIDTH: post spikes counted in the window.
- `last_latency` output LAT_WIDTH: most recent pre→post latency completed in the window.
- `lat_valid` output 1: at least one pre→post pairing completed in the window.
- `cnt_sat` output 1: a counter saturated during the window.
- `overrun` output 1: sticky; a snapshot was dropped due to backpressure.

## Operation
- FSM states: IDLE and COUNT.
  - IDLE: when `en`=1, latch `window_len` into `win_q` (0 is read as 2^WIN_BITS), clear the window counters, and go to COUNT.
  - COUNT: count cycles 0..win_q-1. Spikes are sampled on every COUNT cycle, including the last one.
- Window end (last COUNT cycle):
  - Take a snapshot of the counts, latency and flags.
  - If `en`=1, re-latch `window_len` and start the next window on the following cycle. There is no gap cycle and no lost spikes.
  - If `en`=0, go to IDLE.
- Spike counters:
  - Increment on each spike and saturate at 2^CNT_WIDTH-1.
  - A spike arriving while a counter is already at max sets `cnt_sat` for that window.
  - Counters are cleared at window start.
- Latency tracker:
  - State is `armed`/`lat_run`, and it persists across window boundaries.
  - A `pre_spike` re-arms the tracker with `lat_run`=0, restarting on every pre spike.
  - While armed, `lat_run` increments each cycle and saturates at 2^LAT_WIDTH-1.
  - A `post_spike` while armed records the latency (cycles since the last pre), sets the window's `lat_valid`, and disarms.
  - Pre and post in the same cycle: latency 0, pairing recorded, tracker left disarmed.
  - A post while disarmed is counted but not paired.
  - The window's `last_latency` holds the last pairing completed within that window, or 0 if none.
- Output buffer (single entry):
  - A snapshot loads the buffer if it is empty, or if it is being accepted that same cycle (`out_valid & out_ready`).
  - Otherwise the snapshot is dropped, the held record is unchanged, and `overrun` is set.
  - `overrun` clears only on `reset`.
  - The record and `out_valid` stay stable until accepted.
- Reset mid-operation: the FSM goes to IDLE and all counters, the tracker, the buffer and the outputs clear on the next edge. No record is emitted.

## Timing
- Reset values: every output is 0.
- The first COUNT cycle is the cycle after the IDLE cycle in which `en`=1.
- A window spans exactly win_q COUNT cycles.
- `out_valid` rises on the cycle after the window's last cycle, so latency is 1 cycle.
- Handshake transfer: the record transfers on an edge where `out_valid`=`out_ready`=1. `out_valid` falls on the next cycle unless a new snapshot loads on that same edge.
- Latency definition: a pre at cycle t and a post at cycle t+k gives `last_latency`=k, saturating at 2^LAT_WIDTH-1.
- Dropping `en` mid-window does not truncate the window. The window completes and then returns to IDLE.

## Test plan
- Reset: assert `reset` for 2 cycles → all outputs 0 and FSM in IDLE. With `en`=0, no record appears for 100 cycles.
- Basic window: `window_len`=10, `en` held 1, pre at window cycles 2 and 5, post at cycle 8 → record `pre_count`=2, `post_count`=1, `last_latency`=3, `lat_valid`=1, `cnt_sat`=0. `out_valid` rises 1 cycle after cycle 9.
- Saturation: `window_len`=0 (256 cycles), `pre_spike` held 1 for the whole window → `pre_count`=255, `cnt_sat`=1, and the next window starts with no gap.
- Latency edges: pre and post in the same cycle → latency 0. Pre followed by post 300 cycles later → latency 255. A second pre at +4 before the post at +6 → latency 2.
- Backpressure: `window_len`=5, `out_ready`=0 for 12 cycles → first record held unchanged, `overrun`=1. Raise `out_ready` → first record accepted, and later records flow normally with `overrun` still 1.
- Stop and reset: drop `en` at window cycle 3 of 8 → full 8-cycle record emitted, then IDLE. Assert `reset` mid-window → no record, and outputs are 0 next cycle.
